// File: rtl/soc_mem_arbiter_if.sv
// Core-side OBI-style bus interfaces for the CV32E40P instruction and data
// ports. The arbiter connects to both through their Slave modports.

interface CORE_INST_INF;
  logic        instr_req;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;

  modport Master (
    output instr_req, instr_addr,
    input  instr_gnt, instr_rvalid, instr_rdata
  );

  modport Slave (
    input  instr_req, instr_addr,
    output instr_gnt, instr_rvalid, instr_rdata
  );
endinterface

interface CORE_DATA_INF;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;

  modport Master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport Slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: shares one OBI-style memory port between the core's
// instruction and data masters. A request that is waiting for its grant keeps
// the port locked to its master; every granted transfer records its source in
// an in-order FIFO so the response is returned to the master that issued it.
// Build option: define SOC_MEM_ARB_RR_EN for round-robin tie-breaking;
// without it the data master always wins a tie.

module soc_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  CORE_INST_INF.Slave inst,
  CORE_DATA_INF.Slave data,
  output logic [31:0] mem_addr_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        protocol_err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic SRC_INSTR = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  // Pointer advance with wrap at the FIFO depth (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return ptr + PTR_ONE;
    end
  endfunction

  logic                       lock_q, lock_d;
  logic                       lock_sel_q, lock_sel_d;
  logic                       last_q, last_d;
  logic                       err_q, err_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;

  logic sel_valid_s;
  logic sel_src_s;
  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic head_src_s;

  assign full_s         = (count_q == CNT_MAX);
  assign empty_s        = (count_q == CNT_ZERO);
  assign protocol_err_o = err_q;

  // Pick which master owns the shared port this cycle.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_src_s   = SRC_DATA;
    if (rst_i) begin
      sel_valid_s = 1'b0;
    end else if (full_s) begin
      // No room to remember another response owner; a same-cycle pop does not help.
      sel_valid_s = 1'b0;
    end else if (lock_q) begin
      sel_valid_s = 1'b1;
      sel_src_s   = lock_sel_q;
    end else if (inst.instr_req && data.data_req) begin
      sel_valid_s = 1'b1;
`ifdef SOC_MEM_ARB_RR_EN
      sel_src_s   = ~last_q;
`else
      sel_src_s   = SRC_DATA;
`endif
    end else if (data.data_req) begin
      sel_valid_s = 1'b1;
      sel_src_s   = SRC_DATA;
    end else if (inst.instr_req) begin
      sel_valid_s = 1'b1;
      sel_src_s   = SRC_INSTR;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // Forward the selected master's request and return the grant to it alone.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_addr_o     = 32'h0000_0000;
    mem_we_o       = 1'b0;
    mem_be_o       = 4'h0;
    mem_wdata_o    = 32'h0000_0000;
    inst.instr_gnt = 1'b0;
    data.data_gnt  = 1'b0;
    if (sel_valid_s && (sel_src_s == SRC_DATA)) begin
      mem_req_o     = data.data_req;
      mem_addr_o    = data.data_addr;
      mem_we_o      = data.data_we;
      mem_be_o      = data.data_be;
      mem_wdata_o   = data.data_wdata;
      data.data_gnt = mem_gnt_i;
    end else if (sel_valid_s) begin
      mem_req_o      = inst.instr_req;
      mem_addr_o     = inst.instr_addr;
      mem_we_o       = 1'b0;
      mem_be_o       = 4'hF;
      mem_wdata_o    = 32'h0000_0000;
      inst.instr_gnt = mem_gnt_i;
    end else begin
      mem_req_o = 1'b0;
    end
  end

  // Route each response to the owner recorded at the FIFO head.
  always_comb begin
    push_s            = mem_req_o && mem_gnt_i;
    pop_s             = mem_rvalid_i && !empty_s;
    head_src_s        = fifo_q[rd_ptr_q];
    inst.instr_rvalid = !rst_i && pop_s && (head_src_s == SRC_INSTR);
    data.data_rvalid  = !rst_i && pop_s && (head_src_s == SRC_DATA);
    inst.instr_rdata  = mem_rdata_i;
    data.data_rdata   = mem_rdata_i;
  end

  // Next-state for lock, round-robin history, routing FIFO and error flag.
  always_comb begin
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    last_d     = last_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_d      = err_q || (mem_rvalid_i && empty_s);

    if (push_s) begin
      lock_d           = 1'b0;
      last_d           = sel_src_s;
      fifo_d[wr_ptr_q] = sel_src_s;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else if (mem_req_o) begin
      lock_d     = 1'b1;
      lock_sel_d = sel_src_s;
    end else begin
      lock_d = lock_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers; last_q resets to data so the first round-robin tie goes to instr.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_sel_q <= SRC_DATA;
      last_q     <= SRC_DATA;
      err_q      <= 1'b0;
      count_q    <= CNT_ZERO;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      fifo_q     <= {MAX_OUTSTANDING{1'b0}};
    end else begin
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      last_q     <= last_d;
      err_q      <= err_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_q     <= fifo_d;
    end
  end

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Directed bench for soc_mem_arbiter. Each granted transfer pushes its expected
// owner onto a queue; each memory response pops the queue and checks routing.
// Tie expectations follow SOC_MEM_ARB_RR_EN when the bench is built with it.

module tb_soc_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] mem_addr_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        protocol_err_o;

  CORE_INST_INF inst_if();
  CORE_DATA_INF data_if();

  soc_mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .inst           (inst_if),
    .data           (data_if),
    .mem_addr_o     (mem_addr_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .protocol_err_o (protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_q[$];
  bit exp_last = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit tie_pick();
`ifdef SOC_MEM_ARB_RR_EN
    return ~exp_last;
`else
    return 1'b1;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    inst_if.instr_req = 1'b0;
    data_if.data_req  = 1'b0;
    mem_gnt_i         = 1'b0;
    mem_rvalid_i      = 1'b0;
    mem_rdata_i       = 32'h0000_0000;
  endtask

  task automatic chk_fwd(input string tag, input bit src);
    if (src) begin
      chk({tag, ".addr"},  mem_addr_o,  data_if.data_addr);
      chk({tag, ".we"},    {31'h0, mem_we_o}, {31'h0, data_if.data_we});
      chk({tag, ".be"},    {28'h0, mem_be_o}, {28'h0, data_if.data_be});
      chk({tag, ".wdata"}, mem_wdata_o, data_if.data_wdata);
    end else begin
      chk({tag, ".addr"},  mem_addr_o,  inst_if.instr_addr);
      chk({tag, ".we"},    {31'h0, mem_we_o}, 32'h0000_0000);
      chk({tag, ".be"},    {28'h0, mem_be_o}, 32'h0000_000F);
      chk({tag, ".wdata"}, mem_wdata_o, 32'h0000_0000);
    end
  endtask

  task automatic chk_grant(input string tag, input bit src);
    chk({tag, ".req"},   {31'h0, mem_req_o},          32'h0000_0001);
    chk({tag, ".igntt"}, {31'h0, inst_if.instr_gnt},  {31'h0, ~src});
    chk({tag, ".dgnt"},  {31'h0, data_if.data_gnt},   {31'h0, src});
    chk_fwd(tag, src);
    exp_q.push_back(src);
    exp_last = src;
  endtask

  task automatic chk_wait(input string tag, input bit src);
    chk({tag, ".req"},  {31'h0, mem_req_o},         32'h0000_0001);
    chk({tag, ".ignt"}, {31'h0, inst_if.instr_gnt}, 32'h0000_0000);
    chk({tag, ".dgnt"}, {31'h0, data_if.data_gnt},  32'h0000_0000);
    chk_fwd(tag, src);
  endtask

  task automatic chk_blocked(input string tag);
    chk({tag, ".req"},  {31'h0, mem_req_o},         32'h0000_0000);
    chk({tag, ".ignt"}, {31'h0, inst_if.instr_gnt}, 32'h0000_0000);
    chk({tag, ".dgnt"}, {31'h0, data_if.data_gnt},  32'h0000_0000);
    chk({tag, ".addr"}, mem_addr_o,                 32'h0000_0000);
  endtask

  task automatic chk_no_resp(input string tag);
    chk({tag, ".irv"}, {31'h0, inst_if.instr_rvalid}, 32'h0000_0000);
    chk({tag, ".drv"}, {31'h0, data_if.data_rvalid},  32'h0000_0000);
  endtask

  task automatic chk_resp(input string tag);
    bit src;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s observed=response expected=no_pending_transfer", tag);
    end else begin
      src = exp_q.pop_front();
      chk({tag, ".irv"},   {31'h0, inst_if.instr_rvalid}, {31'h0, ~src});
      chk({tag, ".drv"},   {31'h0, data_if.data_rvalid},  {31'h0, src});
      chk({tag, ".irdat"}, inst_if.instr_rdata, mem_rdata_i);
      chk({tag, ".drdat"}, data_if.data_rdata,  mem_rdata_i);
    end
  endtask

  initial begin
    bit src;
    // Reset with every input active: nothing may leak through.
    rst_i               = 1'b1;
    inst_if.instr_req   = 1'b1;
    inst_if.instr_addr  = 32'h0000_0100;
    data_if.data_req    = 1'b1;
    data_if.data_addr   = 32'h0000_0300;
    data_if.data_we     = 1'b1;
    data_if.data_be     = 4'h3;
    data_if.data_wdata  = 32'hCAFE_0000;
    mem_gnt_i           = 1'b1;
    mem_rvalid_i        = 1'b1;
    mem_rdata_i         = 32'h1234_5678;
    #3;
    chk_blocked("rst");
    chk_no_resp("rst");
    chk("rst.err", {31'h0, protocol_err_o}, 32'h0000_0000);
    cyc();
    cyc();
    rst_i = 1'b0;
    idle();
    cyc();

    // Single instruction transfer, response one cycle later.
    inst_if.instr_req = 1'b1;
    mem_gnt_i         = 1'b1;
    #2;
    chk_grant("single", 1'b0);
    cyc();
    inst_if.instr_req = 1'b0;
    mem_gnt_i         = 1'b0;
    mem_rvalid_i      = 1'b1;
    mem_rdata_i       = 32'hDEAD_BEEF;
    #2;
    chk_resp("single_rsp");
    cyc();
    idle();

    // Continuous tie, memory always grants, latency one.
    inst_if.instr_addr = 32'h0000_0200;
    inst_if.instr_req  = 1'b1;
    data_if.data_req   = 1'b1;
    mem_gnt_i          = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid_i = (i > 0);
      mem_rdata_i  = 32'h1000_0000 + i;
      #2;
      if (i > 0) chk_resp($sformatf("tie_rsp%0d", i));
      src = tie_pick();
      chk_grant($sformatf("tie_gnt%0d", i), src);
      cyc();
    end
    inst_if.instr_req = 1'b0;
    data_if.data_req  = 1'b0;
    mem_gnt_i         = 1'b0;
    mem_rvalid_i      = 1'b1;
    mem_rdata_i       = 32'h1000_0004;
    #2;
    chk_resp("tie_rsp4");
    cyc();
    idle();

    // Lock on data while instr joins; grant withheld for three cycles.
    data_if.data_req   = 1'b1;
    inst_if.instr_addr = 32'h0000_0280;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) inst_if.instr_req = 1'b1;
      #2;
      chk_wait($sformatf("lockA%0d", i), 1'b1);
      cyc();
    end
    mem_gnt_i = 1'b1;
    #2;
    chk_grant("lockA_gnt", 1'b1);
    cyc();
    idle();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h2000_0001;
    #2;
    chk_resp("lockA_rsp");
    cyc();
    idle();

    // Lock on instr while data (which would win a fixed tie) joins.
    inst_if.instr_req  = 1'b1;
    inst_if.instr_addr = 32'h0000_0400;
    #2;
    chk_wait("lockB0", 1'b0);
    cyc();
    data_if.data_req = 1'b1;
    #2;
    chk_wait("lockB1", 1'b0);
    cyc();
    mem_gnt_i = 1'b1;
    #2;
    chk_grant("lockB_gnt", 1'b0);
    cyc();
    inst_if.instr_req = 1'b0;
    mem_rvalid_i      = 1'b1;
    mem_rdata_i       = 32'h3000_0001;
    #2;
    chk_resp("lockB_rsp0");
    chk_grant("lockB_gnt2", 1'b1);
    cyc();
    data_if.data_req = 1'b0;
    mem_gnt_i        = 1'b0;
    mem_rdata_i      = 32'h3000_0002;
    #2;
    chk_resp("lockB_rsp1");
    cyc();
    idle();

    // FIFO full: two grants (I then D), responses delayed.
    inst_if.instr_addr = 32'h0000_0500;
    inst_if.instr_req  = 1'b1;
    mem_gnt_i          = 1'b1;
    #2;
    chk_grant("full_g0", 1'b0);
    cyc();
    inst_if.instr_req = 1'b0;
    data_if.data_req  = 1'b1;
    #2;
    chk_grant("full_g1", 1'b1);
    cyc();
    inst_if.instr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk_blocked($sformatf("full_blk%0d", i));
      cyc();
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h4000_0001;
    #2;
    chk_resp("full_rsp0");
    chk_blocked("full_popblk");
    cyc();
    mem_rdata_i = 32'h4000_0002;
    #2;
    chk_resp("full_rsp1");
    src = tie_pick();
    chk_grant("full_pushpop", src);
    cyc();
    mem_rvalid_i = 1'b0;
    #2;
    src = tie_pick();
    chk_grant("full_g2", src);
    cyc();
    #2;
    chk_blocked("full_blk_again");
    cyc();
    idle();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h4000_0003;
    #2;
    chk_resp("full_rsp2");
    cyc();
    mem_rdata_i = 32'h4000_0004;
    #2;
    chk_resp("full_rsp3");
    cyc();
    idle();

    // Response with nothing outstanding.
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hBAD0_0001;
    #2;
    chk_no_resp("orphan");
    chk("orphan.err_same", {31'h0, protocol_err_o}, 32'h0000_0000);
    cyc();
    idle();
    #2;
    chk("orphan.err_next", {31'h0, protocol_err_o}, 32'h0000_0001);
    cyc();
    #2;
    chk("orphan.err_sticky", {31'h0, protocol_err_o}, 32'h0000_0001);
    cyc();

    // Reset pulse with a transfer in flight.
    inst_if.instr_req = 1'b1;
    mem_gnt_i         = 1'b1;
    #2;
    chk("midrst.gnt", {31'h0, inst_if.instr_gnt}, 32'h0000_0001);
    cyc();
    rst_i            = 1'b1;
    data_if.data_req = 1'b1;
    mem_rvalid_i     = 1'b1;
    #2;
    chk_blocked("midrst");
    chk_no_resp("midrst");
    chk("midrst.we",    {31'h0, mem_we_o},  32'h0000_0000);
    chk("midrst.be",    {28'h0, mem_be_o},  32'h0000_0000);
    chk("midrst.wdata", mem_wdata_o,        32'h0000_0000);
    chk("midrst.err",   {31'h0, protocol_err_o}, 32'h0000_0000);
    cyc();
    rst_i = 1'b0;
    idle();
    exp_q.delete();
    exp_last = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5000_0001;
    #2;
    chk_no_resp("late_rsp");
    cyc();
    idle();
    #2;
    chk("late_rsp.err", {31'h0, protocol_err_o}, 32'h0000_0001);
    cyc();

    // First tie after reset.
    inst_if.instr_req = 1'b1;
    data_if.data_req  = 1'b1;
    mem_gnt_i         = 1'b1;
    #2;
    src = tie_pick();
    chk_grant("post_rst_tie", src);
    cyc();
    idle();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h6000_0001;
    #2;
    chk_resp("post_rst_rsp");
    cyc();
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
